// File: rtl/move_collector.sv
// move_collector: snapshots 16 move slots on load, scans one slot per cycle, queues non-empty words in a FWFT FIFO.
// Latency: slot i is pushed i+1 edges after load; head word is visible the cycle after its push into an empty FIFO.
// Backpressure: a full FIFO stalls the scan on the current slot; MOVE_COLLECTOR_CAPTURE_FIRST_EN scans twice, captures first.
module move_collector #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [511:0]                 move_in,
    input  logic                         load,
    input  logic                         flush,
    output logic                         busy,
    output logic                         scan_done,
    output logic [4:0]                   gen_count,
    output logic [31:0]                  move_out,
    output logic                         move_valid,
    input  logic                         move_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t         state_q, state_d;
    logic [511:0]   snap_q, snap_d;
    logic [3:0]     idx_q, idx_d;
    logic [4:0]     gen_count_q, gen_count_d;
    logic           scan_done_q, scan_done_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    mem_q [DEPTH];
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    logic           pass_q, pass_d;
`endif

    logic [31:0]    cur_word;
    logic           qualify;
    logic           fifo_full;
    logic           push;
    logic           stall;
    logic           pop;
    logic           mem_we;

    assign cur_word  = snap_q[{idx_q, 5'd0} +: 32];
    assign fifo_full = (cnt_q == CW'(DEPTH));

`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    // Pass 0 takes captures only, pass 1 takes the remaining non-empty quiet moves.
    assign qualify = pass_q ? ((cur_word != 32'd0) && (cur_word[29:24] == 6'd0))
                            : (cur_word[29:24] != 6'd0);
`else
    assign qualify = (cur_word != 32'd0);
`endif

    assign push   = (state_q == S_SCAN) && qualify && !fifo_full;
    assign stall  = (state_q == S_SCAN) && qualify && fifo_full;
    assign pop    = move_valid && move_ready;
    assign mem_we = push && !flush;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        gen_count_d = gen_count_q;
        scan_done_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
        pass_d      = pass_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (gen_count_q != 5'd31) begin
                gen_count_d = gen_count_q + 5'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    snap_d      = move_in;
                    idx_d       = 4'd0;
                    gen_count_d = 5'd0;
                    state_d     = S_SCAN;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
                    pass_d      = 1'b0;
`endif
                end
            end
            S_SCAN: begin
                if (!stall) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
                        if (!pass_q) begin
                            pass_d = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            scan_done_d = 1'b1;
                        end
`else
                        state_d     = S_IDLE;
                        scan_done_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over load, push, pop and completion in the same cycle.
        if (flush) begin
            state_d     = S_IDLE;
            idx_d       = 4'd0;
            gen_count_d = 5'd0;
            scan_done_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
            pass_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            idx_q       <= 4'd0;
            gen_count_q <= 5'd0;
            scan_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
            pass_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            gen_count_q <= gen_count_d;
            scan_done_q <= scan_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
            pass_q      <= pass_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= cur_word;
        end
    end

    assign busy       = (state_q == S_SCAN);
    assign scan_done  = scan_done_q;
    assign gen_count  = gen_count_q;
    assign move_valid = (cnt_q != '0);
    assign move_out   = move_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign fifo_count = cnt_q;

endmodule

// File: doc/move_collector.md
# move_collector

Serializes the sixteen 32-bit move words produced by one board square (eight sliding/king/pawn directions plus eight knight jumps) into a single stream for the search engine. On `load` it snapshots all sixteen slots, scans them one per cycle, drops empty (all-zero) words and pushes the rest into a first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. The block sits directly downstream of `square`.

## Interface
- `DEPTH`, default 16: FIFO entries. Power of two, at least 2.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `move_in`  in  512: slot s occupies bits [32s+31:32s]. Slot order: 0 U, 1 D, 2 L, 3 R, 4 UL, 5 UR, 6 DL, 7 DR, 8 UUL, 9 UUR, 10 LLU, 11 RRU, 12 DDL, 13 DDR, 14 LLD, 15 RRD.
- `load`  in  1: start a scan of `move_in`.
- `flush`  in  1: synchronous abort of the scan and clear of the FIFO.
- `busy`  out  1: scan in progress.
- `scan_done`  out  1: one-cycle pulse when a scan completes.
- `gen_count`  out  5: number of words pushed since the last accepted `load`.
- `move_out`  out  32: FIFO head word.
- `move_valid`  out  1: FIFO not empty.
- `move_ready`  in  1: consumer accepts `move_out`.
- `fifo_count`  out  $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- Move word fields: [29:24] captured piece, [21:16] from square, [13:9] moving piece/colour, [5:0] to square, all other bits 0. A word of 0 is empty. A word is a capture when [29:24] != 0.
- States:
  - IDLE: `load` latches `move_in` into `snap`, clears `idx` and `gen_count`, then goes to SCAN.
  - SCAN: examines `snap[idx]` each cycle.
    - A qualifying word is pushed when the FIFO is not full, then `idx` increments.
    - An empty or non-qualifying word increments `idx` with no push.
    - When a qualifying word meets a full FIFO, `idx` holds (stall) and the slot is retried next cycle.
    - When slot 15 is handled, the pass ends and the block returns to IDLE with `scan_done`=1.
- `load` while `busy` is ignored. The snapshot is not affected by later changes on `move_in`.
- `flush` has priority over everything else, including a same-cycle `load`. It empties the FIFO, sets `gen_count`=0 and returns to IDLE. It does not pulse `scan_done`.
- FIFO behaviour:
  - Pop occurs when `move_valid && move_ready`.
  - Push is blocked whenever `fifo_count==DEPTH`, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves `fifo_count` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- `move_out` is 0 while the FIFO is empty.
- `gen_count` saturates at 31, which cannot be reached with 16 slots.

## Timing
- Reset values: state IDLE, `busy`=0, `scan_done`=0, `gen_count`=0, `move_out`=0, `move_valid`=0, `fifo_count`=0. Pointers and `idx` are cleared to 0.
- When `load` is sampled at edge k:
  - `busy`=1 from edge k through edge k+16.
  - Slot i is pushed at edge k+1+i (no stalls).
  - `move_valid` rises after the first push edge.
- `scan_done` is high for exactly the one cycle following the edge that handles slot 15. `busy` falls at that same edge.
- Each stall cycle delays all later events by one cycle.
- A pushed word is visible on `move_out` the cycle after its push edge when the FIFO was empty. There is no combinational path from `move_in` to `move_out`.
- `move_ready` to pop takes effect at the same edge. The next head word is presented the following cycle.

## Configuration
- `MOVE_COLLECTOR_CAPTURE_FIRST_EN` defined:
  - SCAN runs two passes. Pass 1 pushes only captures; pass 2 pushes only non-empty non-captures.
  - A scan takes 32 cycles without stalls.
  - `scan_done` pulses after slot 15 of pass 2.
  - `flush` aborts either pass.
- Not defined:
  - Single pass; every non-empty word qualifies.
  - Words are emitted in slot order.
  - A scan takes 16 cycles.

## Test plan
- Reset while SCAN with 3 words in the FIFO -> all outputs read zero immediately; after release, `load` starts a clean scan.
- Slots 0, 5, 12 non-empty, `move_ready`=1, macro off -> words emitted in order 0, 5, 12; `gen_count`=3; `scan_done` pulse at cycle 16 after `load`.
- Macro on: slot 2 quiet, slot 9 capture (word 0x0301_2A1C), slot 14 capture -> emitted order 9, 14, 2; `scan_done` at cycle 32.
- DEPTH=4, all 16 slots non-empty, `move_ready`=0 -> `fifo_count`=4, `busy` stays 1 and `idx` stalls at 4. Raising `move_ready` drains all 16 in slot order with no loss or duplication.
- `flush` asserted mid-scan together with `load` -> FIFO empty, `gen_count`=0, IDLE, no `scan_done`, `load` ignored.
- `load` pulsed again during `busy` and `move_in` changed -> the second `load` is ignored and the emitted words match the original snapshot.
